// File: rtl/regfile_ctrl.sv
// regfile_ctrl: Moore instruction sequencer driving the 8x16 register file
// and datapath load/select strobes for MOV/MVN/ADD/CMP/AND.
//
// Ports:
//   clk, reset_n     : rising-edge clock, async active-low reset
//   s, instr         : start handshake and instruction (captured in WAIT)
//   w, err           : ready (WAIT only), illegal-instruction pulse
//   readnum/writenum : regfile read/write selects, write: write strobe
//   loada/b/c/s      : datapath register and status load strobes
//   asel, vsel       : ALU A zero-select, write-back source select
//   aluop, shift     : ALU controls from ir, sximm8: sign-extended ir[7:0]
module regfile_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s,
    input  logic [15:0]  instr,
    output logic         w,
    output logic         err,
    output logic [2:0]   readnum,
    output logic [2:0]   writenum,
    output logic         write,
    output logic         loada,
    output logic         loadb,
    output logic         loadc,
    output logic         loads,
    output logic         asel,
    output logic         vsel,
    output logic [1:0]   aluop,
    output logic [1:0]   shift,
    output logic [W-1:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_CMP_S,
        S_WR_REG,
        S_WR_IMM
    } state_t;

    typedef struct packed {
        logic         w;
        logic         err;
        logic [2:0]   readnum;
        logic [2:0]   writenum;
        logic         write;
        logic         loada;
        logic         loadb;
        logic         loadc;
        logic         loads;
        logic         asel;
        logic         vsel;
        logic [1:0]   aluop;
        logic [1:0]   shift;
        logic [W-1:0] sximm8;
    } out_t;

    state_t      r_state;
    logic [15:0] r_ir;
    out_t        r_out;

    state_t      w_nstate;
    logic [15:0] w_nir;

    function automatic logic is_movi(input logic [15:0] ir);
        return ir[15:11] == 5'b110_10;
    endfunction

    function automatic logic is_movr(input logic [15:0] ir);
        return ir[15:11] == 5'b110_00;
    endfunction

    function automatic logic is_mvn(input logic [15:0] ir);
        return ir[15:11] == 5'b101_11;
    endfunction

    function automatic logic is_cmp(input logic [15:0] ir);
        return ir[15:11] == 5'b101_01;
    endfunction

    function automatic logic is_alu2(input logic [15:0] ir);
        return (ir[15:11] == 5'b101_00) || (ir[15:11] == 5'b101_01) ||
               (ir[15:11] == 5'b101_10);
    endfunction

    // Outputs are a pure function of (state, ir); registering the value
    // for the next state keeps them glitch-free and still Moore.
    function automatic out_t f_out(input state_t st, input logic [15:0] ir);
        out_t o;
        o        = '0;
        o.aluop  = ir[12:11];
        o.shift  = is_movi(ir) ? 2'b00 : ir[4:3];
        o.sximm8 = {{(W-8){ir[7]}}, ir[7:0]};
        unique case (st)
            S_WAIT:   o.w = 1'b1;
            S_DECODE: o.err = ~(is_movi(ir) | is_movr(ir) | is_mvn(ir) |
                                is_alu2(ir));
            S_GET_A: begin
                o.readnum = ir[10:8];
                o.loada   = 1'b1;
            end
            S_GET_B: begin
                o.readnum = ir[2:0];
                o.loadb   = 1'b1;
            end
            S_ALU: begin
                o.loadc = 1'b1;
                o.asel  = is_movr(ir) | is_mvn(ir);
            end
            S_CMP_S:  o.loads = 1'b1;
            S_WR_REG: begin
                o.writenum = ir[7:5];
                o.write    = 1'b1;
            end
            S_WR_IMM: begin
                o.writenum = ir[10:8];
                o.vsel     = 1'b1;
                o.write    = 1'b1;
            end
        endcase
        return o;
    endfunction

    always_comb begin
        w_nstate = r_state;
        w_nir    = r_ir;
        unique case (r_state)
            S_WAIT: begin
                if (s) begin
                    w_nstate = S_DECODE;
                    w_nir    = instr;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_movi(r_ir):                 w_nstate = S_WR_IMM;
                    is_movr(r_ir) | is_mvn(r_ir):  w_nstate = S_GET_B;
                    is_alu2(r_ir):                 w_nstate = S_GET_A;
                    default:                       w_nstate = S_WAIT;
                endcase
            end
            S_GET_A: w_nstate = S_GET_B;
            S_GET_B: w_nstate = S_ALU;
            // CMP also passes through ALU so flags are loaded from a
            // settled ALU result one cycle later; C is never written back.
            S_ALU:    w_nstate = is_cmp(r_ir) ? S_CMP_S : S_WR_REG;
            S_CMP_S:  w_nstate = S_WAIT;
            S_WR_REG: w_nstate = S_WAIT;
            S_WR_IMM: w_nstate = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
            r_out   <= f_out(S_WAIT, 16'h0000);
        end else begin
            r_state <= w_nstate;
            r_ir    <= w_nir;
            r_out   <= f_out(w_nstate, w_nir);
        end
    end

    assign w        = r_out.w;
    assign err      = r_out.err;
    assign readnum  = r_out.readnum;
    assign writenum = r_out.writenum;
    assign write    = r_out.write;
    assign loada    = r_out.loada;
    assign loadb    = r_out.loadb;
    assign loadc    = r_out.loadc;
    assign loads    = r_out.loads;
    assign asel     = r_out.asel;
    assign vsel     = r_out.vsel;
    assign aluop    = r_out.aluop;
    assign shift    = r_out.shift;
    assign sximm8   = r_out.sximm8;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed scoreboard bench for regfile_ctrl.
// Expected per-cycle output vectors are queued with stimulus and popped.
module tb_regfile_ctrl;

    typedef struct packed {
        logic        w;
        logic        err;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        vsel;
        logic [1:0]  aluop;
        logic [1:0]  shift;
        logic [15:0] sximm8;
    } o_t;

    typedef struct {
        string tag;
        o_t    e;
        o_t    m;
    } ent_t;

    logic        clk;
    logic        reset_n;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        vsel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;

    int   checks;
    int   failures;
    ent_t sb[$];
    o_t   act;

    regfile_ctrl #(.W(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .err      (err),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .vsel     (vsel),
        .aluop    (aluop),
        .shift    (shift),
        .sximm8   (sximm8)
    );

    assign act = {w, err, readnum, writenum, write, loada, loadb, loadc,
                  loads, asel, vsel, aluop, shift, sximm8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fields that follow ir in every state.
    function automatic o_t base(input logic [15:0] ir);
        o_t o;
        o        = '0;
        o.aluop  = ir[12:11];
        o.shift  = (ir[15:11] == 5'b11010) ? 2'b00 : ir[4:3];
        o.sximm8 = {{8{ir[7]}}, ir[7:0]};
        return o;
    endfunction

    function automatic o_t idle(input logic [15:0] ir);
        o_t o;
        o   = base(ir);
        o.w = 1'b1;
        return o;
    endfunction

    task automatic pushm(input string t, input o_t e, input o_t m);
        ent_t x;
        x.tag = t;
        x.e   = e;
        x.m   = m;
        sb.push_back(x);
    endtask

    task automatic push(input string t, input o_t e);
        pushm(t, e, '1);
    endtask

    task automatic chk();
        ent_t x;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL sb_empty observed=%h expected=entry", act);
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            assert ((act & x.m) === (x.e & x.m)) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h",
                       x.tag, act & x.m, x.e & x.m);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        chk();
    endtask

    initial begin
        o_t e;
        o_t m;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b1;
        s        = 1'b0;
        instr    = 16'h0000;
        #1 reset_n = 1'b0;
        #1;
        push("rst_state", idle(16'h0000));
        chk();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        push("rst_idle", idle(16'h0000));
        cyc();

        // MOV R3,#-5
        instr = 16'hD3FB;
        s     = 1'b1;
        push("movi_dec", base(16'hD3FB));
        e = base(16'hD3FB);
        e.write = 1'b1; e.writenum = 3'd3; e.vsel = 1'b1;
        push("movi_wr", e);
        push("movi_w", idle(16'hD3FB));
        cyc();
        s = 1'b0;
        cyc();
        cyc();

        // ADD R2,R1,R0 LSL1
        instr = 16'hA148;
        s     = 1'b1;
        push("add_dec", base(16'hA148));
        e = base(16'hA148); e.readnum = 3'd1; e.loada = 1'b1;
        push("add_geta", e);
        e = base(16'hA148); e.readnum = 3'd0; e.loadb = 1'b1;
        push("add_getb", e);
        e = base(16'hA148); e.loadc = 1'b1;
        push("add_alu", e);
        e = base(16'hA148); e.writenum = 3'd2; e.write = 1'b1;
        push("add_wr", e);
        push("add_w", idle(16'hA148));
        cyc();
        s = 1'b0;
        repeat (5) cyc();

        // CMP R4,R5
        instr = 16'hAC05;
        s     = 1'b1;
        push("cmp_dec", base(16'hAC05));
        e = base(16'hAC05); e.readnum = 3'd4; e.loada = 1'b1;
        push("cmp_geta", e);
        e = base(16'hAC05); e.readnum = 3'd5; e.loadb = 1'b1;
        push("cmp_getb", e);
        m = '0; m.w = 1'b1; m.err = 1'b1; m.write = 1'b1; m.loads = 1'b1;
        pushm("cmp_c4", base(16'hAC05), m);
        e = base(16'hAC05); e.loads = 1'b1;
        push("cmp_loads", e);
        push("cmp_w", idle(16'hAC05));
        cyc();
        s = 1'b0;
        repeat (5) cyc();

        // Illegal opcode
        instr = 16'hE000;
        s     = 1'b1;
        e = base(16'hE000); e.err = 1'b1;
        push("ill_err", e);
        push("ill_w", idle(16'hE000));
        cyc();
        s = 1'b0;
        cyc();

        // MVN R7,R1 with ignored start, then back-to-back MOV R1,#7
        instr = 16'hB8E1;
        s     = 1'b1;
        push("mvn_dec", base(16'hB8E1));
        e = base(16'hB8E1); e.readnum = 3'd1; e.loadb = 1'b1;
        push("mvn_getb", e);
        e = base(16'hB8E1); e.loadc = 1'b1; e.asel = 1'b1;
        push("mvn_alu", e);
        e = base(16'hB8E1); e.writenum = 3'd7; e.write = 1'b1;
        push("mvn_wr", e);
        push("mvn_w", idle(16'hB8E1));
        push("b2b_dec", base(16'hD107));
        e = base(16'hD107);
        e.writenum = 3'd1; e.write = 1'b1; e.vsel = 1'b1;
        push("b2b_wr", e);
        push("b2b_w", idle(16'hD107));
        cyc();
        s = 1'b0;
        cyc();
        s     = 1'b1;
        instr = 16'hD107;
        cyc();
        cyc();
        cyc();
        cyc();
        s = 1'b0;
        cyc();
        cyc();

        // Reset in the middle of an ADD
        instr = 16'hA148;
        s     = 1'b1;
        push("radd_dec", base(16'hA148));
        e = base(16'hA148); e.readnum = 3'd1; e.loada = 1'b1;
        push("radd_geta", e);
        e = base(16'hA148); e.readnum = 3'd0; e.loadb = 1'b1;
        push("radd_getb", e);
        cyc();
        s = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b0;
        #1;
        push("rst_async", idle(16'h0000));
        chk();
        @(negedge clk);
        reset_n = 1'b1;
        push("post_rst0", idle(16'h0000));
        push("post_rst1", idle(16'h0000));
        push("post_rst2", idle(16'h0000));
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
